// File: rtl/regfile_write_arbiter_if.sv
// Request-side handshake bundle for regfile_write_arbiter.
// Requesters drive Valid/Addr/Data through the master modport.
// The arbiter returns the one-hot ReqReady grant through the slave modport.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]        ReqReady;

  modport master (output ReqValid, ReqAddr, ReqData, input ReqReady);
  modport slave  (input ReqValid, ReqAddr, ReqData, output ReqReady);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// NUM_REQ requesters. Arbitration uses fixed priority, where a lower index wins.
// A requester that has been blocked MAX_WAIT times in a row is promoted ahead
// of the fixed order. The write port is registered, so each write appears one
// cycle after the grant. Writes to register 0 are suppressed.
// Optional macro REGFILE_CLEAR_EN: after reset, the arbiter writes zero to
// registers 1..31 before it starts accepting requests.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | zeroing registers 1..31, no grants (REGFILE_CLEAR_EN only)
//   ST_ARB   | normal arbitration, one write per cycle
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_write_arbiter_if.slave reqBus,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  Stall,
  output logic                  InitDone
);

`ifdef REGFILE_CLEAR_EN
  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;
  localparam state_t            RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(31);
  logic [ADDR_W-1:0] clrCnt;
`else
  typedef enum logic [0:0] {ST_ARB = 1'b0} state_t;
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t             state, stateNext;
  logic [3:0]         waitCnt [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] grant;
  logic               picked;
  logic [ADDR_W-1:0]  grantAddr;
  logic [DATA_W-1:0]  grantData;
  logic               transfer;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= RESET_STATE;
    else       state <= stateNext;
  end

  // Next-state logic: the clear sweep ends on the edge that writes the last register.
  always_comb begin
    stateNext = state;
    case (state)
      ST_ARB:   stateNext = ST_ARB;
`ifdef REGFILE_CLEAR_EN
      ST_CLEAR: if (clrCnt == CLR_LAST) stateNext = ST_ARB;
`endif
      default:  stateNext = ST_ARB;
    endcase
  end

  // Output logic: promote starved requesters first, then apply fixed priority.
  always_comb begin
    starved   = '0;
    grant     = '0;
    picked    = 1'b0;
    grantAddr = '0;
    grantData = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = reqBus.ReqValid[i] && (waitCnt[i] >= 4'(MAX_WAIT));
    if (!Reset && state == ST_ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!picked && starved[i]) begin
          grant[i] = 1'b1;
          picked   = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!picked && reqBus.ReqValid[i]) begin
          grant[i] = 1'b1;
          picked   = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantAddr = reqBus.ReqAddr[i*ADDR_W +: ADDR_W];
        grantData = reqBus.ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

  assign reqBus.ReqReady = grant;
  assign transfer        = |grant;
  assign Stall           = !Reset && |(reqBus.ReqValid & ~grant);

  // Wait counters: count consecutive blocked cycles, saturate at 15, clear when granted or idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REQ; i++) waitCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqBus.ReqValid[i] && !grant[i]) begin
          if (waitCnt[i] != 4'hF) waitCnt[i] <= waitCnt[i] + 4'd1;
        end else begin
          waitCnt[i] <= '0;
        end
      end
    end
  end

  // Registered write port. Address and data always load on a grant; only the enable honours $zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      InitDone      <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      clrCnt        <= ADDR_W'(1);
`endif
    end else begin
      InitDone <= (stateNext == ST_ARB);
      RegWrite <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      if (state == ST_CLEAR) begin
        RegWrite      <= 1'b1;
        WriteRegister <= clrCnt;
        WriteData     <= '0;
        clrCnt        <= clrCnt + ADDR_W'(1);
      end else
`endif
      if (transfer) begin
        RegWrite      <= (grantAddr != '0);
        WriteRegister <= grantAddr;
        WriteData     <= grantData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Each step drives the requests,
// checks the combinational grant and Stall, and pushes the expected write.
// After the clock edge, the expected write is popped and compared with the
// registered write port.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              Stall;
  logic              InitDone;

  int  checks = 0;
  int  errors = 0;
  wr_t sbQ[$];

  regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) reqBus ();

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .reqBus(reqBus),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .Stall(Stall),
    .InitDone(InitDone)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int idx, input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    reqBus.ReqValid[idx]                = v;
    reqBus.ReqAddr[idx*ADDR_W +: ADDR_W] = a;
    reqBus.ReqData[idx*DATA_W +: DATA_W] = d;
  endtask

  task automatic checkOut(input string tag);
    wr_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      chk({tag, ".rw"},   32'(RegWrite),      32'(e.rw));
      chk({tag, ".addr"}, 32'(WriteRegister), 32'(e.addr));
      chk({tag, ".data"}, WriteData,          e.data);
    end else begin
      chk({tag, ".rw_idle"}, 32'(RegWrite), 32'd0);
    end
  endtask

  // One clock step, entered and left at the falling edge.
  task automatic cycle(input string tag, input logic [2:0] expReady, input logic expStall);
    wr_t e;
    #1;
    chk({tag, ".ready"}, 32'(reqBus.ReqReady), 32'(expReady));
    chk({tag, ".stall"}, 32'(Stall), 32'(expStall));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (expReady[i]) begin
        e.addr = reqBus.ReqAddr[i*ADDR_W +: ADDR_W];
        e.data = reqBus.ReqData[i*DATA_W +: DATA_W];
        e.rw   = (e.addr != '0);
        sbQ.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
    checkOut(tag);
    @(negedge Clk);
  endtask

`ifdef REGFILE_CLEAR_EN
  task automatic clearSweep(input string tag);
    wr_t e;
    for (int k = 1; k <= 31; k++) begin
      #1;
      chk({tag, ".ready"}, 32'(reqBus.ReqReady), 32'd0);
      chk({tag, ".init_pre"}, 32'(InitDone), 32'd0);
      e.rw   = 1'b1;
      e.addr = ADDR_W'(k);
      e.data = '0;
      sbQ.push_back(e);
      @(posedge Clk);
      #1;
      checkOut(tag);
      chk({tag, ".init"}, 32'(InitDone), (k == 31) ? 32'd1 : 32'd0);
      @(negedge Clk);
    end
  endtask
`endif

  // Directed sequence.
  initial begin
    Reset           = 1'b1;
    reqBus.ReqValid = '0;
    reqBus.ReqAddr  = '0;
    reqBus.ReqData  = '0;

    // Reset state
    @(negedge Clk);
    setReq(2, 1'b1, 5'd4, 32'h4);
    #1;
    chk("rst.ready", 32'(reqBus.ReqReady), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst.rw",   32'(RegWrite), 32'd0);
    chk("rst.addr", 32'(WriteRegister), 32'd0);
    chk("rst.data", WriteData, 32'd0);
    chk("rst.init", 32'(InitDone), 32'd0);
    @(negedge Clk);
    setReq(2, 1'b0, '0, '0);
    Reset = 1'b0;

`ifdef REGFILE_CLEAR_EN
    setReq(1, 1'b1, 5'd8, 32'd77);
    clearSweep("t6");
    setReq(1, 1'b0, '0, '0);
    cycle("t6.idle", 3'b000, 1'b0);
`else
    cycle("init.idle", 3'b000, 1'b0);
    chk("init.done", 32'(InitDone), 32'd1);
`endif

    // Test 1: single write
    setReq(1, 1'b1, 5'd8, 32'd77);
    cycle("t1", 3'b010, 1'b0);
    setReq(1, 1'b0, '0, '0);
    cycle("t1.after", 3'b000, 1'b0);

    // Test 2: fixed priority, back-to-back writes
    setReq(0, 1'b1, 5'd9, 32'd5);
    setReq(2, 1'b1, 5'd10, 32'd6);
    cycle("t2.a", 3'b001, 1'b1);
    setReq(0, 1'b0, '0, '0);
    cycle("t2.b", 3'b100, 1'b0);
    setReq(2, 1'b0, '0, '0);
    cycle("t2.idle", 3'b000, 1'b0);

    // Test 3: starvation promotion, twice to show the counter cleared
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 5; c++) begin
        setReq(0, 1'b1, ADDR_W'(c), 32'h100 + 32'(r*8 + c));
        setReq(2, 1'b1, 5'd12, 32'h200 + 32'(r));
        if (c < 5) cycle("t3.blk", 3'b001, 1'b1);
        else       cycle("t3.promo", 3'b100, 1'b1);
      end
    end
    setReq(0, 1'b0, '0, '0);
    setReq(2, 1'b0, '0, '0);
    cycle("t3.idle", 3'b000, 1'b0);

    // Test 4: writes to $zero are suppressed
    setReq(0, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle("t4", 3'b001, 1'b0);
    setReq(0, 1'b0, '0, '0);
    cycle("t4.idle", 3'b000, 1'b0);

    // Test 5: reset mid-stream
    setReq(1, 1'b1, 5'd3, 32'h33);
    cycle("t5.pre", 3'b010, 1'b0);
    setReq(1, 1'b1, 5'd8, 32'd77);
    Reset = 1'b1;
    cycle("t5.rst", 3'b000, 1'b0);
    chk("t5.rst.addr", 32'(WriteRegister), 32'd0);
    chk("t5.rst.data", WriteData, 32'd0);
    chk("t5.rst.init", 32'(InitDone), 32'd0);
    Reset = 1'b0;
`ifdef REGFILE_CLEAR_EN
    clearSweep("t5.clr");
`endif
    cycle("t5.reacc", 3'b010, 1'b0);
    chk("t5.init", 32'(InitDone), 32'd1);
    setReq(1, 1'b0, '0, '0);
    cycle("t5.idle", 3'b000, 1'b0);

    chk("sb.empty", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
